serial_sub_ctrl: RTL
====================

Name: serial_sub_ctrl

Overview:
Bit-serial subtraction controller. It computes A - B over WIDTH clock cycles using one single-bit full-subtractor cell. The cell is built from two half-subtractor stages plus an OR, and it is fed LSB-first by this block's shift registers and borrow flip-flop. The block sits between a simple start/done requester and the single-bit subtract datapath, and it owns all sequencing: operand loading, bit counting, borrow propagation and result capture. It is the area-minimal alternative to a WIDTH-bit ripple subtractor.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)
CNT_W, $clog2(WIDTH), width of the internal bit counter (derived; not overridden)

Ports:
clk   input   1      single clock; all state changes on its rising edge
rst   input   1      synchronous, active-high reset
start input   1      request; sampled only in IDLE
a     input   WIDTH  minuend; captured on the accepted start edge
b     input   WIDTH  subtrahend; captured on the accepted start edge
busy  output  1      high in RUN and DONE
done  output  1      one-cycle pulse, high in DONE
dif   output  WIDTH  registered result (a - b) mod 2^WIDTH
br    output  1      registered final borrow; 1 iff a < b (unsigned)

Behaviour:
- Reset (rst=1 at a rising edge, any state):
  - state=IDLE; busy=0, done=0, dif=0, br=0.
  - Shift registers, borrow flip-flop and counter are cleared.
  - An operation in flight is abandoned with no done pulse.
  - rst takes priority over start.
- FSM, three states: IDLE, RUN, DONE.
  - IDLE: on start=1, load a_sh=a, b_sh=b, bin=0, cnt=0, then go to RUN. start=0 stays in IDLE.
  - RUN: each edge processes bit 0 of a_sh/b_sh:
    - d = a0 ^ b0 ^ bin
    - bout = (~a0 & b0) | (~(a0 ^ b0) & bin)
    - d is shifted into res_sh at the MSB; a_sh and b_sh shift right; bin <= bout; cnt <= cnt + 1.
    - On the edge where cnt == WIDTH-1: dif <= final res_sh (including this bit), br <= bout, go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE; it is not queued. A start held high in DONE is accepted on the following IDLE edge.
- Latency:
  - Accepted start at edge E0; bits are processed at E1..E_WIDTH.
  - done is high in the cycle after E_WIDTH, and dif/br are valid in that same cycle.
  - Total: WIDTH+1 cycles from the start edge to done high; minimum issue interval is WIDTH+2 cycles.
- dif and br change only at completion. They hold their last result through IDLE and the next RUN until overwritten.
- busy = (state != IDLE); done = (state == DONE). Both are decoded from registered state, with no combinational path from inputs.
- Arithmetic: unsigned, modulo 2^WIDTH. br is the borrow out of the MSB.
- a and b are don't-care except on the accepted start edge; mid-operation input changes have no effect.
- Unused state encodings recover to IDLE on the next edge.

Decomposition:
- Shared include/package holds the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
- One natural sub-module: full_subtractor_bit (inputs a, b, bin; outputs d, bout). It is built from two half-subtractor instances (a−b, then result−bin) whose borrows are ORed.
- Controller, shift registers and counter stay in serial_sub_ctrl.

Test Plan:
- Basic subtract: WIDTH=8, start with a=8'h5A, b=8'h23 -> done pulses 9 cycles after the start edge, dif=8'h37, br=0, busy high for exactly 9 cycles.
- Underflow: a=8'h00, b=8'h01 -> dif=8'hFF, br=1. Then a=8'h10, b=8'h80 -> dif=8'h90, br=1.
- Equal and extreme operands:
  - a=b=8'h80 -> dif=8'h00, br=0.
  - a=8'hFF, b=8'h00 -> dif=8'hFF, br=0.
- Start while busy: start a=8'h0F, b=8'h01, then pulse start with a=8'hAA, b=8'h55 at cycle 3 -> single done, dif=8'h0E, br=0, second request ignored.
- Reset mid-operation: assert rst at cycle 4 of RUN -> next cycle busy=0, done=0, dif=0, br=0, no done pulse. A following start with a=8'h09, b=8'h04 -> dif=8'h05.
- Back-to-back with start held high: keep start=1, first a=8'h03, b=8'h05 -> dif=8'hFE, br=1. The next operation is accepted on the first IDLE edge after DONE, giving WIDTH+2 cycle spacing between done pulses.

Source files
------------

// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtraction controller:
// controller state encodings and the default operand width.
package serial_sub_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_ctrl_full_subtractor_bit.sv
// Single-bit subtract cell: two half-subtractor stages (a-b, then
// that difference minus the incoming borrow) with their borrows ORed.

module half_subtractor (
  input  logic i_a,
  input  logic i_b,
  output logic o_d,
  output logic o_bout
);
  assign o_d    = i_a ^ i_b;
  assign o_bout = ~i_a & i_b;
endmodule

module full_subtractor_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);
  logic w_d1;
  logic w_b1;
  logic w_b2;

  half_subtractor u_hs_ab (
    .i_a    (i_a),
    .i_b    (i_b),
    .o_d    (w_d1),
    .o_bout (w_b1)
  );

  half_subtractor u_hs_bin (
    .i_a    (w_d1),
    .i_b    (i_bin),
    .o_d    (o_d),
    .o_bout (w_b2)
  );

  // The two stages can never both borrow, so OR gives the combined borrow.
  assign o_bout = w_b1 | w_b2;
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B controller: loads the operands, feeds one bit per
// cycle LSB-first through a single full-subtractor cell, carries the
// borrow in a flip-flop and captures the result after WIDTH bits.
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | waiting for start; dif/br hold the last result
// RUN     | one operand bit processed per clock, WIDTH clocks total
// DONE    | one-cycle done pulse, dif/br valid; back to IDLE

module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dif,
  output logic             br
);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  // Only WIDTH-1 result bits need storage: the last bit goes straight
  // from the cell into dif on the completing edge.
  logic [WIDTH-2:0] r_res_sh;
  logic             r_bin;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_dif;
  logic             r_br;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_full;

  full_subtractor_bit u_fsb (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_bin  (r_bin),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  // Result register as it looks after this cycle's bit enters at the MSB.
  assign w_res_full = {w_d, r_res_sh};

  // Sequencing FSM with datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_bin    <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dif    <= '0;
      r_br     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_bin   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_res_sh <= w_res_full[WIDTH-1:1];
          r_bin    <= w_bout;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH-1)) begin
            r_dif   <= w_res_full;
            r_br    <= w_bout;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dif  = r_dif;
  assign br   = r_br;

endmodule
